collision_array: RTL

Parametrised multi-ghost collision checker for the Pacman game core. On a `start` pulse it snapshots the player position and N ghost positions. It then streams the ghosts one per cycle through a shared 3-stage squared-distance pipeline and publishes a per-ghost collision mask, an any-hit flag and the lowest-index hit. It sits between the sprite-position registers and the game-state controller, replacing single-pair, free-running checking.

---
 rtl/collision_pkg.sv | 20 ++
 rtl/dist_sq_pipe.sv | 71 +++++++
 rtl/collision_array.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types and sizing helpers for the multi-ghost collision checker.
package collision_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH
  } state_t;

  localparam int COORD_W_DEF = 9;

  function automatic int dist_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

  function automatic int thresh(input int radius);
    return radius * radius;
  endfunction

endpackage

// File: rtl/dist_sq_pipe.sv
// Valid-tagged squared-distance datapath: abs-difference, square, then a
// combinational sum/compare whose result the caller registers as stage 3.
module dist_sq_pipe
  import collision_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int RADIUS  = 12,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IDW-1:0]     in_id,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] mx,
  input  logic [COORD_W-1:0] my,
  output logic               out_valid,
  output logic [IDW-1:0]     out_id,
  output logic               out_hit,
  output logic               pipe_busy
);

  localparam int DW = dist_w(COORD_W);
  localparam logic [DW-1:0] TH = DW'(thresh(RADIUS));

  // Differences are read as two's complement; the top bit is the sign.
  function automatic logic [COORD_W-1:0] mag(input logic [COORD_W:0] d);
    return d[COORD_W] ? (~d[COORD_W-1:0] + COORD_W'(1)) : d[COORD_W-1:0];
  endfunction

  logic [COORD_W:0]     diff_x, diff_y;
  logic                 s1_valid, s2_valid;
  logic [IDW-1:0]       s1_id, s2_id;
  logic [COORD_W-1:0]   s1_dx, s1_dy;
  logic [2*COORD_W-1:0] s2_sqx, s2_sqy;
  logic [DW-1:0]        sum;

  assign diff_x = {1'b0, px} - {1'b0, mx};
  assign diff_y = {1'b0, py} - {1'b0, my};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_sqx   <= '0;
      s2_sqy   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_id    <= in_id;
      s1_dx    <= mag(diff_x);
      s1_dy    <= mag(diff_y);
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_sqx   <= {{COORD_W{1'b0}}, s1_dx} * {{COORD_W{1'b0}}, s1_dx};
      s2_sqy   <= {{COORD_W{1'b0}}, s1_dy} * {{COORD_W{1'b0}}, s1_dy};
    end
  end

  // Full-width sum: two maximal squares cannot overflow DW bits.
  assign sum       = {1'b0, s2_sqx} + {1'b0, s2_sqy};
  assign out_hit   = (sum < TH);
  assign out_valid = s2_valid;
  assign out_id    = s2_id;
  assign pipe_busy = s1_valid | s2_valid;

endmodule

// File: rtl/collision_array.sv
// Multi-ghost collision sweep: snapshots positions on start, streams ghosts
// through dist_sq_pipe and commits a hit mask. Optional COLLISION_EDGE_EN adds col_new.
module collision_array
  import collision_pkg::*;
#(
  parameter int  COORD_W  = COORD_W_DEF,
  parameter int  N_GHOSTS = 4,
  parameter int  RADIUS   = 12,
  localparam int IDW      = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [COORD_W-1:0]          p_x,
  input  logic [COORD_W-1:0]          p_y,
  input  logic [N_GHOSTS*COORD_W-1:0] m_x,
  input  logic [N_GHOSTS*COORD_W-1:0] m_y,
  output logic                        busy,
  output logic                        done,
  output logic                        col,
  output logic [N_GHOSTS-1:0]         col_mask,
  output logic [IDW-1:0]              first_id
`ifdef COLLISION_EDGE_EN
  ,
  output logic [N_GHOSTS-1:0]         col_new
`endif
);

  localparam logic [IDW-1:0] LAST = IDW'(N_GHOSTS - 1);

  state_t               state, next_state;
  logic                 launch, commit;
  logic [IDW-1:0]       idx;
  logic [COORD_W-1:0]   snap_px, snap_py;
  logic [COORD_W-1:0]   gx [N_GHOSTS];
  logic [COORD_W-1:0]   gy [N_GHOSTS];
  logic [N_GHOSTS-1:0]  work_mask;
  logic [IDW-1:0]       enc;
  logic                 out_valid, out_hit, pipe_busy;
  logic [IDW-1:0]       out_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    commit     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (idx == LAST) next_state = FLUSH;
      end
      FLUSH: begin
        // Commit one cycle after the last hit bit lands in the working mask.
        if (!pipe_busy) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  dist_sq_pipe #(
    .COORD_W(COORD_W),
    .RADIUS (RADIUS),
    .IDW    (IDW)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state == SCAN),
    .in_id    (idx),
    .px       (snap_px),
    .py       (snap_py),
    .mx       (gx[idx]),
    .my       (gy[idx]),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_hit  (out_hit),
    .pipe_busy(pipe_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      snap_px   <= '0;
      snap_py   <= '0;
      work_mask <= '0;
      for (int i = 0; i < N_GHOSTS; i++) begin
        gx[i] <= '0;
        gy[i] <= '0;
      end
    end else begin
      if (launch) begin
        idx       <= '0;
        snap_px   <= p_x;
        snap_py   <= p_y;
        work_mask <= '0;
        for (int i = 0; i < N_GHOSTS; i++) begin
          gx[i] <= m_x[i*COORD_W +: COORD_W];
          gy[i] <= m_y[i*COORD_W +: COORD_W];
        end
      end else begin
        if (state == SCAN) idx <= idx + IDW'(1);
        if (out_valid) work_mask[out_id] <= out_hit;
      end
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N_GHOSTS - 1; i >= 0; i--) begin
      if (work_mask[i]) enc = IDW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      col      <= 1'b0;
      col_mask <= '0;
      first_id <= '0;
`ifdef COLLISION_EDGE_EN
      col_new  <= '0;
`endif
    end else begin
      done <= commit;
      if (commit) begin
        col      <= |work_mask;
        col_mask <= work_mask;
        first_id <= enc;
`ifdef COLLISION_EDGE_EN
        col_new  <= work_mask & ~col_mask;
`endif
      end
    end
  end

endmodule
